// File: rtl/ilm_pkg.sv
// ------------------------------------------------------------------
// ilm_pkg : shared width helpers for the nearest-one ILM pipeline
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package ilm_pkg;

  localparam int ILM_ITER_MAX = 1;

  // NOD code spans 0..WIDTH, so it needs clog2(WIDTH+1) bits
  function automatic int nod_code_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int res_w(input int w);
    return w + 1;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w + 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ilm_nod_n.sv
// ------------------------------------------------------------------
// ilm_nod_n : combinational nearest-one detector -> {zero, k, code}
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module ilm_nod_n
  import ilm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]             i_v,
  output logic                         o_zero,
  output logic [WIDTH:0]               o_k,
  output logic [nod_code_w(WIDTH)-1:0] o_code
);

  localparam int CW = nod_code_w(WIDTH);

  logic [CW-1:0] w_msb;
  logic          w_round;
  logic          w_below;

  // Scan upward: the last set bit is the MSB, the bit under it decides rounding
  always_comb begin
    w_msb   = '0;
    w_round = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_v[i]) begin
        w_msb   = CW'(i);
        w_round = w_below;
      end
      w_below = i_v[i];
    end
  end

  assign o_zero = ~|i_v;
  assign o_code = o_zero ? '0 : (w_msb + CW'(w_round));
  assign o_k    = o_zero ? '0 : ({{WIDTH{1'b0}}, 1'b1} << o_code);

endmodule

`default_nettype wire

// File: rtl/ilm_nod_pipe.sv
// ------------------------------------------------------------------
// ilm_nod_pipe : pipelined NOD iterative log multiplier, valid/ready
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module ilm_nod_pipe
  import ilm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = 0,
  parameter int TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o,
  output logic [TAG_W-1:0]   tag_o
);

  localparam int CW = nod_code_w(WIDTH);
  localparam int RW = res_w(WIDTH);
  localparam int PW = prod_w(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  function automatic logic [PW-1:0] sext(input logic [RW-1:0] r);
    return {{(PW-RW){r[RW-1]}}, r};
  endfunction

  logic                 r_out_vld;
  logic [2*WIDTH-1:0]   r_p;
  logic [TAG_W-1:0]     r_tag;
  logic                 w_adv;

  // Whole pipeline freezes while the output is blocked
  assign w_adv       = ~(r_out_vld & ~out_ready_i);
  assign in_ready_o  = w_adv;
  assign out_valid_o = r_out_vld;
  assign p_o         = r_p;
  assign tag_o       = r_tag;

  logic            w_x_zero, w_y_zero;
  logic [WIDTH:0]  w_x_k, w_y_k;
  logic [CW-1:0]   w_x_code, w_y_code;
  logic [RW-1:0]   w_rx, w_ry;

  ilm_nod_n #(.WIDTH(WIDTH)) u_nod_x (
    .i_v(x_i), .o_zero(w_x_zero), .o_k(w_x_k), .o_code(w_x_code)
  );
  ilm_nod_n #(.WIDTH(WIDTH)) u_nod_y (
    .i_v(y_i), .o_zero(w_y_zero), .o_k(w_y_k), .o_code(w_y_code)
  );

  assign w_rx = {1'b0, x_i} - w_x_k;
  assign w_ry = {1'b0, y_i} - w_y_k;

  logic             r_s1_vld;
  logic             r_s1_zero;
  logic [TAG_W-1:0] r_s1_tag;
  logic [CW-1:0]    r_s1_cx, r_s1_cy;
  logic [RW-1:0]    r_s1_rx, r_s1_ry;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld  <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_tag  <= '0;
      r_s1_cx   <= '0;
      r_s1_cy   <= '0;
      r_s1_rx   <= '0;
      r_s1_ry   <= '0;
    end else if (w_adv) begin
      r_s1_vld <= in_valid_i;
      if (in_valid_i) begin
        r_s1_zero <= w_x_zero | w_y_zero;
        r_s1_tag  <= tag_i;
        r_s1_cx   <= w_x_code;
        r_s1_cy   <= w_y_code;
        r_s1_rx   <= w_rx;
        r_s1_ry   <= w_ry;
      end
    end
  end

  logic [CW:0]   w_s2_csum;
  logic [PW-1:0] w_s2_t0, w_s2_tx, w_s2_ty;

  assign w_s2_csum = {1'b0, r_s1_cx} + {1'b0, r_s1_cy};
  assign w_s2_t0   = {{(PW-1){1'b0}}, 1'b1} << w_s2_csum;
  assign w_s2_tx   = sext(r_s1_rx) << r_s1_cy;
  assign w_s2_ty   = sext(r_s1_ry) << r_s1_cx;

  logic             r_s2_vld;
  logic             r_s2_zero;
  logic [TAG_W-1:0] r_s2_tag;
  logic [PW-1:0]    r_s2_t0, r_s2_tx, r_s2_ty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_vld  <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_tag  <= '0;
      r_s2_t0   <= '0;
      r_s2_tx   <= '0;
      r_s2_ty   <= '0;
    end else if (w_adv) begin
      r_s2_vld  <= r_s1_vld;
      r_s2_zero <= r_s1_zero;
      r_s2_tag  <= r_s1_tag;
      r_s2_t0   <= w_s2_t0;
      r_s2_tx   <= w_s2_tx;
      r_s2_ty   <= w_s2_ty;
    end
  end

  logic             w_p3_vld;
  logic             w_p3_zero;
  logic [TAG_W-1:0] w_p3_tag;
  logic [PW-1:0]    w_p3_t0, w_p3_tx, w_p3_ty, w_p3_c;

  if (ITER >= ILM_ITER_MAX) begin : g_iter1
    // |r| never exceeds 2^(WIDTH-2), so the low WIDTH bits carry the magnitude
    logic [WIDTH-1:0] w_arx, w_ary;
    logic             w_arx_zero, w_ary_zero;
    logic [WIDTH:0]   w_arx_k, w_ary_k;
    logic [CW-1:0]    w_arx_code, w_ary_code;

    assign w_arx = r_s1_rx[RW-1] ? (~r_s1_rx[WIDTH-1:0] + ONE_W) : r_s1_rx[WIDTH-1:0];
    assign w_ary = r_s1_ry[RW-1] ? (~r_s1_ry[WIDTH-1:0] + ONE_W) : r_s1_ry[WIDTH-1:0];

    ilm_nod_n #(.WIDTH(WIDTH)) u_nod_rx (
      .i_v(w_arx), .o_zero(w_arx_zero), .o_k(w_arx_k), .o_code(w_arx_code)
    );
    ilm_nod_n #(.WIDTH(WIDTH)) u_nod_ry (
      .i_v(w_ary), .o_zero(w_ary_zero), .o_k(w_ary_k), .o_code(w_ary_code)
    );

    logic          r_c_zero, r_c_neg;
    logic [CW-1:0] r_c_cx, r_c_cy;
    logic [RW-1:0] r_c_rx, r_c_ry;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_c_zero <= 1'b1;
        r_c_neg  <= 1'b0;
        r_c_cx   <= '0;
        r_c_cy   <= '0;
        r_c_rx   <= '0;
        r_c_ry   <= '0;
      end else if (w_adv) begin
        r_c_zero <= w_arx_zero | w_ary_zero;
        r_c_neg  <= r_s1_rx[RW-1] ^ r_s1_ry[RW-1];
        r_c_cx   <= w_arx_code;
        r_c_cy   <= w_ary_code;
        r_c_rx   <= {1'b0, w_arx} - w_arx_k;
        r_c_ry   <= {1'b0, w_ary} - w_ary_k;
      end
    end

    logic [CW:0]   w_b_csum;
    logic [PW-1:0] w_b_mag;

    assign w_b_csum = {1'b0, r_c_cx} + {1'b0, r_c_cy};
    assign w_b_mag  = ({{(PW-1){1'b0}}, 1'b1} << w_b_csum)
                    + (sext(r_c_rx) << r_c_cy)
                    + (sext(r_c_ry) << r_c_cx);

    logic             r_b_vld;
    logic             r_b_zero;
    logic [TAG_W-1:0] r_b_tag;
    logic [PW-1:0]    r_b_t0, r_b_tx, r_b_ty, r_b_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_b_vld  <= 1'b0;
        r_b_zero <= 1'b0;
        r_b_tag  <= '0;
        r_b_t0   <= '0;
        r_b_tx   <= '0;
        r_b_ty   <= '0;
        r_b_c    <= '0;
      end else if (w_adv) begin
        r_b_vld  <= r_s2_vld;
        r_b_zero <= r_s2_zero;
        r_b_tag  <= r_s2_tag;
        r_b_t0   <= r_s2_t0;
        r_b_tx   <= r_s2_tx;
        r_b_ty   <= r_s2_ty;
        r_b_c    <= r_c_zero ? '0 : (r_c_neg ? -w_b_mag : w_b_mag);
      end
    end

    assign w_p3_vld  = r_b_vld;
    assign w_p3_zero = r_b_zero;
    assign w_p3_tag  = r_b_tag;
    assign w_p3_t0   = r_b_t0;
    assign w_p3_tx   = r_b_tx;
    assign w_p3_ty   = r_b_ty;
    assign w_p3_c    = r_b_c;
  end else begin : g_iter0
    assign w_p3_vld  = r_s2_vld;
    assign w_p3_zero = r_s2_zero;
    assign w_p3_tag  = r_s2_tag;
    assign w_p3_t0   = r_s2_t0;
    assign w_p3_tx   = r_s2_tx;
    assign w_p3_ty   = r_s2_ty;
    assign w_p3_c    = '0;
  end

  logic [PW-1:0]      w_sum;
  logic [2*WIDTH-1:0] w_p_fin;

  assign w_sum = w_p3_t0 + w_p3_tx + w_p3_ty + w_p3_c;

  // Sign bit clamps to zero; any bit above 2*WIDTH clamps to all-ones
  always_comb begin
    w_p_fin = w_sum[2*WIDTH-1:0];
    if (w_p3_zero || w_sum[PW-1]) begin
      w_p_fin = '0;
    end else if (|w_sum[PW-2:2*WIDTH]) begin
      w_p_fin = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_vld <= 1'b0;
      r_p       <= '0;
      r_tag     <= '0;
    end else if (w_adv) begin
      r_out_vld <= w_p3_vld;
      if (w_p3_vld) begin
        r_p   <= w_p_fin;
        r_tag <= w_p3_tag;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ilm_nod_pipe.sv
// ------------------------------------------------------------------
// tb_ilm_nod_pipe : self-checking bench for three ilm_nod_pipe builds
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_ilm_nod_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid [3];
  logic        out_ready[3];
  logic [15:0] xs       [3];
  logic [15:0] ys       [3];
  logic [3:0]  tin      [3];

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [15:0] p0, p1;
  logic [31:0] p2;
  logic [3:0]  to0, to1, to2;

  ilm_nod_pipe #(.WIDTH(8), .ITER(0), .TAG_W(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(ir0),
    .x_i(xs[0][7:0]), .y_i(ys[0][7:0]), .tag_i(tin[0]),
    .out_valid_o(ov0), .out_ready_i(out_ready[0]), .p_o(p0), .tag_o(to0));

  ilm_nod_pipe #(.WIDTH(8), .ITER(1), .TAG_W(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(ir1),
    .x_i(xs[1][7:0]), .y_i(ys[1][7:0]), .tag_i(tin[1]),
    .out_valid_o(ov1), .out_ready_i(out_ready[1]), .p_o(p1), .tag_o(to1));

  ilm_nod_pipe #(.WIDTH(16), .ITER(1), .TAG_W(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(ir2),
    .x_i(xs[2]), .y_i(ys[2]), .tag_i(tin[2]),
    .out_valid_o(ov2), .out_ready_i(out_ready[2]), .p_o(p2), .tag_o(to2));

  logic        ir_a[3];
  logic        ov_a[3];
  logic [31:0] p_a [3];
  logic [3:0]  to_a[3];

  always_comb begin
    ir_a[0] = ir0; ov_a[0] = ov0; p_a[0] = {16'b0, p0}; to_a[0] = to0;
    ir_a[1] = ir1; ov_a[1] = ov1; p_a[1] = {16'b0, p1}; to_a[1] = to1;
    ir_a[2] = ir2; ov_a[2] = ov2; p_a[2] = p2;          to_a[2] = to2;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: nearest-one rounding and ILM formula in plain integer arithmetic
  function automatic void nod(input longint v, output longint k, output int c);
    int n;
    k = 0;
    c = 0;
    if (v == 0) return;
    n = 0;
    while ((longint'(1) << (n + 1)) <= v) n++;
    c = n;
    if (n >= 1 && ((v >> (n - 1)) & 1) == 1) c = n + 1;
    k = longint'(1) << c;
  endfunction

  function automatic longint ilm0(input longint a, input longint b);
    longint ka, kb;
    int     ca, cb;
    nod(a, ka, ca);
    nod(b, kb, cb);
    return (longint'(1) << (ca + cb)) + (a - ka) * (longint'(1) << cb)
         + (b - kb) * (longint'(1) << ca);
  endfunction

  function automatic longint model(input longint x, input longint y, input int w, input int iter);
    longint kx, ky, rx, ry, p, c, pmax;
    int     cx, cy;
    nod(x, kx, cx);
    nod(y, ky, cy);
    rx = x - kx;
    ry = y - ky;
    p  = ilm0(x, y);
    if (iter == 1 && rx != 0 && ry != 0) begin
      c = ilm0(rx < 0 ? -rx : rx, ry < 0 ? -ry : ry);
      if ((rx < 0) != (ry < 0)) c = -c;
      p = p + c;
    end
    pmax = (longint'(1) << (2 * w)) - 1;
    if (x == 0 || y == 0 || p < 0) return 0;
    if (p > pmax) return pmax;
    return p;
  endfunction

  typedef struct {
    logic [63:0] p;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_p;
  logic [3:0]  prev_tag;

  task automatic cycle(input int d, input logic v, input logic [15:0] xv, input logic [15:0] yv,
                       input logic [3:0] tv, input longint ep, input logic rdy,
                       output logic acc, output logic got);
    exp_t e;
    @(negedge clk);
    in_valid[d]  = v;
    xs[d]        = xv;
    ys[d]        = yv;
    tin[d]       = tv;
    out_ready[d] = rdy;
    #1;
    acc = v & ir_a[d];
    got = 1'b0;
    if (prev_stall) begin
      chk("hold_valid", ov_a[d], 1);
      chk("hold_p", p_a[d], prev_p);
      chk("hold_tag", to_a[d], prev_tag);
    end
    if (ov_a[d] && rdy) begin
      got = 1'b1;
      chk("spurious_output", exp_q.size() == 0, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("p", p_a[d], e.p);
        chk("tag", to_a[d], e.tag);
      end
    end
    prev_stall = ov_a[d] & ~rdy;
    prev_p     = p_a[d];
    prev_tag   = to_a[d];
    if (acc) exp_q.push_back('{p: ep, tag: tv});
  endtask

  task automatic single_op(input int d, input logic [15:0] xv, input logic [15:0] yv,
                           input logic [3:0] tv, input longint ep, input int lat);
    logic acc, got;
    int   n;
    cycle(d, 1'b1, xv, yv, tv, ep, 1'b1, acc, got);
    chk("accept", acc, 1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      cycle(d, 1'b0, '0, '0, '0, 0, 1'b1, acc, got);
      n++;
    end
    chk("latency", n, lat);
  endtask

  int corner[$];

  task automatic stream(input int d, input int w, input int iter, input int nops, input bit sweep);
    logic        acc, got, v, rdy;
    logic [15:0] xv, yv;
    logic [3:0]  tv;
    int          issued, cyc;
    longint      mask;
    issued     = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    mask       = (longint'(1) << w) - 1;
    while ((issued < nops || exp_q.size() > 0) && cyc < nops * 8 + 100) begin
      if (sweep) begin
        xv  = 16'(corner[issued / corner.size()]);
        yv  = 16'(corner[issued % corner.size()]);
        v   = (issued < nops);
        rdy = 1'b1;
      end else begin
        case ($urandom_range(0, 7))
          0:       xv = '0;
          1:       xv = 16'(mask);
          default: xv = 16'($urandom & mask);
        endcase
        case ($urandom_range(0, 7))
          0:       yv = '0;
          1:       yv = 16'(mask);
          default: yv = 16'($urandom & mask);
        endcase
        v   = (issued < nops) && ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
      end
      tv = 4'($urandom);
      cycle(d, v, xv, yv, tv, model(longint'(xv), longint'(yv), w, iter), rdy, acc, got);
      if (acc) issued++;
      cyc++;
    end
    chk("stream_issued", issued, nops);
    chk("stream_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    int          d;
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  tag;
    longint      p;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, got;
    int   issued, delivered, seen;

    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      xs[d]        = '0;
      ys[d]        = '0;
      tin[d]       = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", ov_a[d], 0);
      chk("rst_p", p_a[d], 0);
      chk("rst_tag", to_a[d], 0);
      chk("rst_in_ready", ir_a[d], 1);
    end

    vecs[0] = '{0, 16'd3,   16'd3,   4'd1, 8};
    vecs[1] = '{0, 16'd13,  16'd11,  4'd2, 152};
    vecs[2] = '{0, 16'd255, 16'd255, 4'd3, 65024};
    vecs[3] = '{0, 16'd0,   16'd200, 4'd4, 0};
    vecs[4] = '{0, 16'd1,   16'd1,   4'd5, 1};
    vecs[5] = '{1, 16'd3,   16'd3,   4'd6, 9};
    vecs[6] = '{1, 16'd13,  16'd11,  4'd7, 144};
    vecs[7] = '{1, 16'd255, 16'd255, 4'd8, 65025};
    vecs[8] = '{1, 16'd200, 16'd0,   4'd9, 0};
    for (int i = 0; i < 9; i++) begin
      single_op(vecs[i].d, vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].p,
                (vecs[i].d == 0) ? 3 : 4);
    end

    // Backpressure: six back-to-back ops, consumer stalls cycles 2..6
    issued     = 0;
    delivered  = 0;
    prev_stall = 1'b0;
    for (int t = 0; t < 40 && (issued < 6 || exp_q.size() > 0); t++) begin
      cycle(0, issued < 6, 16'(20 + issued * 17), 16'(7 + issued * 29), 4'(issued + 10),
            model(longint'(20 + issued * 17), longint'(7 + issued * 29), 8, 0),
            !(t >= 2 && t <= 6), acc, got);
      chk("bp_in_ready", ir_a[0], (t >= 3 && t <= 6) ? 0 : 1);
      if (acc) issued++;
      if (got) delivered++;
    end
    chk("bp_delivered", delivered, 6);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b1, 16'(5 + i), 16'(9 + i), 4'(i), 0, 1'b1, acc, got);
    end
    @(negedge clk);
    rst_n        = 1'b0;
    in_valid[0]  = 1'b0;
    #1;
    chk("midrst_out_valid", ov_a[0], 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1'b0, '0, '0, '0, 0, 1'b1, acc, got);
      if (ov_a[0]) seen++;
    end
    chk("post_rst_stale", seen, 0);
    single_op(0, 16'd3, 16'd3, 4'd12, 8, 3);

    stream(0, 8, 0, 4000, 1'b0);
    stream(1, 8, 1, 4000, 1'b0);
    stream(2, 16, 1, 2000, 1'b0);

    for (int k = 0; k < 16; k++) corner.push_back(1 << k);
    for (int k = 0; k < 15; k++) corner.push_back(3 << k);
    corner.push_back(65535);
    stream(2, 16, 1, corner.size() * corner.size(), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
